lcd_responder: RTL

LCD_RESPONDER -- requirements
Module: lcd_responder

---
 rtl/lcd_resp_pkg.sv | 54 +++++
 rtl/lcd_e_sync.sv | 52 +++++
 rtl/lcd_responder.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_resp_pkg.sv
// lcd_resp_pkg: shared types and constants for the LCD responder.
// The whole display mirror, command decode and bus sampling use these.
package lcd_resp_pkg;

   // Interface mode of the display bus.
   typedef enum logic [1:0] {
      INIT8  = 2'd0,
      NIB_HI = 2'd1,
      NIB_LO = 2'd2
   } mode_e;

   // One synchronized sample of the writer's bus.
   typedef struct packed {
      logic       rs;
      logic       rw;
      logic [3:0] dat;
   } bus_t;

   // Result of mapping a DDRAM address onto the 32-character mirror.
   typedef struct packed {
      logic       hit;
      logic [4:0] idx;
   } ddram_hit_t;

   localparam int NUM_CHARS = 32;

   localparam logic [7:0] CMD_CLR       = 8'h01;
   localparam logic [7:0] CMD_HOME      = 8'h02;
   localparam logic [7:0] CMD_HOME_MASK = 8'hFE;  // bit 0 of Home is don't-care
   localparam logic [7:0] CMD_SET_DDRAM = 8'h80;  // any byte with bit 7 set
   localparam logic [3:0] FUNC_SET_4BIT = 4'h2;   // upper nibble of Function Set, DL=0

   localparam logic [7:0] CHAR_SPACE = 8'h20;

   localparam logic [6:0] LINE0_BASE = 7'h00;
   localparam logic [6:0] LINE1_BASE = 7'h40;

   // Map a 7-bit DDRAM address to a mirror index; only the first 16
   // positions of each line are mirrored, everything else misses.
   function automatic ddram_hit_t ddram_to_idx(input logic [6:0] addr);
      ddram_hit_t r;
      r.hit = 1'b0;
      r.idx = 5'd0;
      if (addr[6:4] == LINE0_BASE[6:4]) begin
         r.hit = 1'b1;
         r.idx = {1'b0, addr[3:0]};
      end else if (addr[6:4] == LINE1_BASE[6:4]) begin
         r.hit = 1'b1;
         r.idx = {1'b1, addr[3:0]};
      end
      return r;
   endfunction

endpackage

// File: rtl/lcd_e_sync.sv
// lcd_e_sync: brings the writer's asynchronous enable strobe into the clk
// domain and flags its falling edge. rs/rw/dat travel through the same
// two-flop delay so they line up with the synchronized strobe.
module lcd_e_sync
   import lcd_resp_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       e_in,
   input  logic       rs_in,
   input  logic       rw_in,
   input  logic [3:0] dat_in,
   output logic       e_lvl,
   output logic       e_fall,
   output bus_t       bus
);

   logic [1:0] e_sync_q, e_sync_d;
   logic       e_prev_q, e_prev_d;
   bus_t       bus_meta_q, bus_meta_d;
   bus_t       bus_sync_q, bus_sync_d;

   // Next-state for the synchronizer chains and the edge-detect history.
   always_comb begin
      e_sync_d   = {e_sync_q[0], e_in};
      e_prev_d   = e_sync_q[1];
      bus_meta_d = '{rs: rs_in, rw: rw_in, dat: dat_in};
      bus_sync_d = bus_meta_q;
   end

   // Synchronizer flops.
   // NOTE: clocked state is always updated with <= so every flop samples
   // the pre-edge value of its neighbours; = here would collapse the chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_sync_q   <= 2'b00;
         e_prev_q   <= 1'b0;
         bus_meta_q <= '0;
         bus_sync_q <= '0;
      end else begin
         e_sync_q   <= e_sync_d;
         e_prev_q   <= e_prev_d;
         bus_meta_q <= bus_meta_d;
         bus_sync_q <= bus_sync_d;
      end
   end

   assign e_lvl  = e_sync_q[1];
   assign e_fall = e_prev_q & ~e_sync_q[1];
   assign bus    = bus_sync_q;

endmodule

// File: rtl/lcd_responder.sv
// lcd_responder: behavioural stand-in for an HD44780-style character LCD.
// Decodes 8-bit init strobes and 4-bit nibble pairs, mirrors 32 characters,
// tracks the cursor and models the busy time of each instruction.
// Optional read-back of busy flag / address / character data is built when
// the macro LCD_RESP_READ_EN is defined; otherwise read strobes are ignored.
module lcd_responder #(
   parameter int CLR_BUSY_CYCLES = 2000,
   parameter int CMD_BUSY_CYCLES = 50
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         lcd_e,
   input  logic         lcd_rs,
   input  logic         lcd_rw,
   input  logic [3:0]   lcd_dat,
   output logic [3:0]   lcd_dout,
   output logic         lcd_doe,
   output logic [255:0] strdata,
   output logic [4:0]   cur_idx,
   output logic         busy,
   output logic         err_busy,
   output logic         cls_pulse
);

   import lcd_resp_pkg::*;

`ifdef LCD_RESP_READ_EN
   localparam bit READ_EN = 1'b1;
`else
   localparam bit READ_EN = 1'b0;
`endif

   localparam int MAX_BUSY = (CLR_BUSY_CYCLES > CMD_BUSY_CYCLES) ? CLR_BUSY_CYCLES
                                                                 : CMD_BUSY_CYCLES;
   localparam int CNT_W    = $clog2(MAX_BUSY + 1);

   logic e_lvl;
   logic e_fall;
   bus_t s_bus;

   lcd_e_sync u_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .e_in   (lcd_e),
      .rs_in  (lcd_rs),
      .rw_in  (lcd_rw),
      .dat_in (lcd_dat),
      .e_lvl  (e_lvl),
      .e_fall (e_fall),
      .bus    (s_bus)
   );

   mode_e            mode_q, mode_d;
   logic [3:0]       hi_nib_q, hi_nib_d;
   logic             rs_q, rs_d;
   logic             rw_q, rw_d;
   logic [7:0]       chars_q [NUM_CHARS];
   logic [7:0]       chars_d [NUM_CHARS];
   logic [4:0]       cur_q, cur_d;
   logic             busy_q, busy_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             cls_q, cls_d;
   logic             doe_q, doe_d;
   logic [3:0]       dout_q, dout_d;

   logic             is_read;
   logic             blocked;
   logic             exec;
   logic             exec_rs;
   logic [7:0]       exec_byte;
   ddram_hit_t       hit;
   logic             rd_lo;
   logic             rd_rs;
   logic             rd_rw;
   logic [7:0]       rd_char;

   // Strobe decode, instruction execution, busy countdown and read-back.
   // NOTE: every variable gets a default at the top of the block, so no
   // path through the if/case tree can leave one unassigned (no latches).
   always_comb begin
      mode_d    = mode_q;
      hi_nib_d  = hi_nib_q;
      rs_d      = rs_q;
      rw_d      = rw_q;
      chars_d   = chars_q;
      cur_d     = cur_q;
      busy_d    = busy_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      cls_d     = 1'b0;
      exec      = 1'b0;
      exec_rs   = 1'b0;
      exec_byte = 8'h00;
      hit       = '0;

      // The low-nibble strobe inherits rw from its high nibble when reads
      // exist; without read support every rw=1 strobe is simply dropped.
      is_read = (READ_EN && mode_q == NIB_LO) ? rw_q : s_bus.rw;
      // The last busy cycle already counts as free.
      blocked = busy_q && (cnt_q != CNT_W'(1));

      if (busy_q) begin
         if (cnt_q == CNT_W'(1)) begin
            busy_d = 1'b0;
            cnt_d  = '0;
         end else begin
            cnt_d = cnt_q - CNT_W'(1);
         end
      end

      if (e_fall) begin
         if (is_read) begin
            // Reads only step the nibble phase; busy does not block them.
            if (READ_EN) begin
               case (mode_q)
                  NIB_HI: begin
                     rs_d   = s_bus.rs;
                     rw_d   = 1'b1;
                     mode_d = NIB_LO;
                  end
                  NIB_LO:  mode_d = NIB_HI;
                  default: mode_d = mode_q;
               endcase
            end
         end else if (blocked) begin
            err_d = 1'b1;
         end else begin
            case (mode_q)
               INIT8: begin
                  exec      = 1'b1;
                  exec_rs   = s_bus.rs;
                  exec_byte = {s_bus.dat, 4'h0};
                  if (!s_bus.rs && s_bus.dat == FUNC_SET_4BIT) mode_d = NIB_HI;
               end
               NIB_HI: begin
                  hi_nib_d = s_bus.dat;
                  rs_d     = s_bus.rs;
                  rw_d     = 1'b0;
                  mode_d   = NIB_LO;
               end
               default: begin
                  exec      = 1'b1;
                  exec_rs   = rs_q;
                  exec_byte = {hi_nib_q, s_bus.dat};
                  mode_d    = NIB_HI;
               end
            endcase
         end
      end

      if (exec) begin
         busy_d = 1'b1;
         cnt_d  = CNT_W'(CMD_BUSY_CYCLES);
         if (exec_rs) begin
            chars_d[cur_q] = exec_byte;
            cur_d          = cur_q + 5'd1;
         end else if (exec_byte == CMD_CLR) begin
            for (int i = 0; i < NUM_CHARS; i++) chars_d[i] = CHAR_SPACE;
            cur_d = 5'd0;
            cls_d = 1'b1;
            cnt_d = CNT_W'(CLR_BUSY_CYCLES);
         end else if ((exec_byte & CMD_HOME_MASK) == CMD_HOME) begin
            cur_d = 5'd0;
         end else if ((exec_byte & CMD_SET_DDRAM) != 8'h00) begin
            hit = ddram_to_idx(exec_byte[6:0]);
            if (hit.hit) cur_d = hit.idx;
         end
      end

      // Read-back data, driven while the synchronized strobe is high.
      rd_lo   = (mode_q == NIB_LO);
      rd_rs   = rd_lo ? rs_q : s_bus.rs;
      rd_rw   = rd_lo ? rw_q : s_bus.rw;
      rd_char = chars_q[cur_q];
      doe_d   = READ_EN && e_lvl && rd_rw;
      dout_d  = 4'h0;
      if (doe_d) begin
         if (rd_rs) dout_d = rd_lo ? rd_char[3:0] : rd_char[7:4];
         else       dout_d = rd_lo ? {1'b0, cur_q[4], 2'b00} : {busy_q, 3'b000};
      end
   end

   // State registers.
   // NOTE: the character mirror is reset like any other flop because its
   // reset contents (all spaces) are architecturally visible on strdata.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q   <= INIT8;
         hi_nib_q <= 4'h0;
         rs_q     <= 1'b0;
         rw_q     <= 1'b0;
         for (int i = 0; i < NUM_CHARS; i++) chars_q[i] <= CHAR_SPACE;
         cur_q    <= 5'd0;
         busy_q   <= 1'b0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
         cls_q    <= 1'b0;
         doe_q    <= 1'b0;
         dout_q   <= 4'h0;
      end else begin
         mode_q   <= mode_d;
         hi_nib_q <= hi_nib_d;
         rs_q     <= rs_d;
         rw_q     <= rw_d;
         chars_q  <= chars_d;
         cur_q    <= cur_d;
         busy_q   <= busy_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
         cls_q    <= cls_d;
         doe_q    <= doe_d;
         dout_q   <= dout_d;
      end
   end

   // Char 0 sits in the top byte of the mirror bus.
   for (genvar g = 0; g < NUM_CHARS; g++) begin : g_pack
      assign strdata[8*(NUM_CHARS-1-g) +: 8] = chars_q[g];
   end

   assign cur_idx   = cur_q;
   assign busy      = busy_q;
   assign err_busy  = err_q;
   assign cls_pulse = cls_q;
   assign lcd_doe   = doe_q;
   assign lcd_dout  = dout_q;

endmodule
